// File: rtl/fence_t_sequencer.sv
// fence_t_sequencer
//   Temporal-fence (fence.t) sequencer. A fence request from commit stalls
//   the frontend, optionally flushes the data cache, then pulses a
//   microarchitectural reset for RST_CYCLES cycles. Finally it pads the
//   fence to a CSR-programmed total duration. The fence latency is then
//   max(pad, natural duration), independent of secret-dependent cache state.
//
// Ports
//   clk_i              clock, rising edge
//   rst_ni             synchronous active-low reset
//   fence_t_i          fence.t request pulse (honoured only in IDLE)
//   fence_t_pad_i      target total fence duration in cycles (latched at start)
//   fence_t_src_sel_i  1 = skip the dcache flush (latched at start)
//   flush_dcache_o     dcache flush request (state FLUSH_DCACHE)
//   flush_dcache_ack_i dcache flush complete (sampled only in FLUSH_DCACHE)
//   rst_uarch_o        reset for predictors/TLBs/icache/scoreboard
//   halt_o             stall fetch and issue while a fence is in progress
//   fence_t_state_o    IDLE=0, FLUSH_DCACHE=1, RST_UARCH=2, PAD=3
//   done_o             one-cycle pulse in the first IDLE cycle after a fence
//   pad_overrun_o      with done_o: natural duration exceeded a nonzero pad

module fence_t_sequencer #(
  parameter int unsigned PAD_W      = 32,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fence_t_i,
  input  logic [PAD_W-1:0] fence_t_pad_i,
  input  logic             fence_t_src_sel_i,
  output logic             flush_dcache_o,
  input  logic             flush_dcache_ack_i,
  output logic             rst_uarch_o,
  output logic             halt_o,
  output logic [1:0]       fence_t_state_o,
  output logic             done_o,
  output logic             pad_overrun_o
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    FLUSH_DCACHE = 2'd1,
    RST_UARCH    = 2'd2,
    PAD          = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PAD_W-1:0] elapsed_q, elapsed_d;
  logic [PAD_W-1:0] pad_q, pad_d;
  logic             src_q, src_d;
  logic [3:0]       rst_cnt_q, rst_cnt_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  // total = number of fence cycles including the current one. One extra bit
  // keeps the comparison correct when the elapsed counter is saturated.
  logic [PAD_W:0]   total;
  logic [PAD_W:0]   pad_ext;
  logic             rst_last;

  assign total    = {1'b0, elapsed_q} + {{PAD_W{1'b0}}, 1'b1};
  assign pad_ext  = {1'b0, pad_q};
  assign rst_last = (rst_cnt_q == 4'(RST_CYCLES - 1));

  // Next-state and next-register logic. The elapsed counter advances on
  // every non-IDLE cycle and sticks at all-ones instead of wrapping.
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    pad_d     = pad_q;
    src_d     = src_q;
    rst_cnt_d = '0;
    done_d    = 1'b0;
    overrun_d = 1'b0;

    if ((state_q != IDLE) && !(&elapsed_q)) begin
      elapsed_d = elapsed_q + {{(PAD_W-1){1'b0}}, 1'b1};
    end

    case (state_q)
      IDLE: begin
        if (fence_t_i) begin
          pad_d     = fence_t_pad_i;
          src_d     = fence_t_src_sel_i;
          elapsed_d = '0;
          state_d   = fence_t_src_sel_i ? RST_UARCH : FLUSH_DCACHE;
        end
      end
      FLUSH_DCACHE: begin
        if (flush_dcache_ack_i) begin
          state_d = RST_UARCH;
        end
      end
      RST_UARCH: begin
        rst_cnt_d = rst_cnt_q + 4'd1;
        if (rst_last) begin
          rst_cnt_d = '0;
          // At this point total equals the natural duration N.
          if (total < pad_ext) begin
            state_d = PAD;
          end else begin
            state_d   = IDLE;
            done_d    = 1'b1;
            overrun_d = (pad_q != '0) && (total > pad_ext);
          end
        end
      end
      PAD: begin
        // Leave on the cycle that brings the fence length up to the pad.
        if (total >= pad_ext) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any fence without done_o.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      elapsed_q <= '0;
      pad_q     <= '0;
      src_q     <= 1'b0;
      rst_cnt_q <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      pad_q     <= pad_d;
      src_q     <= src_d;
      rst_cnt_q <= rst_cnt_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign flush_dcache_o  = (state_q == FLUSH_DCACHE);
  assign rst_uarch_o     = (state_q == RST_UARCH);
  assign halt_o          = (state_q != IDLE);
  assign fence_t_state_o = state_q;
  assign done_o          = done_q;
  assign pad_overrun_o   = overrun_q;

endmodule
